// File: rtl/axil_riscv_ctrl_regfile_pkg.sv
// Shared constants for the RISC-V control register file: AXI response codes,
// reg0 control-bit positions and a register-count helper.
package axil_riscv_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    localparam int CTRL_REG_IDX         = 0;
    localparam int CTRL_BIT_MEM_RESET_N = 0;
    localparam int CTRL_BIT_RUN         = 1;
    localparam int CTRL_BIT_START       = 2;

    // reg0 keeps only mem_reset_n and run; start is a pulse and 31:3 are reserved
    localparam logic [31:0] CTRL_REG0_STORE_MASK = 32'h0000_0003;

    function automatic int total_regs(input int num_ctrl, input int num_stat);
        return num_ctrl + num_stat;
    endfunction

endpackage

// File: rtl/axil_riscv_ctrl_regfile_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the control
// register file (slave).
interface axil_riscv_ctrl_regfile_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    import axil_riscv_pkg::*;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    axi_resp_t           bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    axi_resp_t           rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_riscv_ctrl_regfile_strb_reg.sv
// 32-bit register with per-byte write enables; bits cleared in STORE_MASK are
// never stored and always read as zero.
module axil_strb_reg #(
    parameter logic [31:0] STORE_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  strb,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    logic [31:0] data_q;
    logic [31:0] data_d;

    always_comb begin
        data_d = data_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    data_d[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        data_d = data_d & STORE_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/axil_riscv_ctrl_regfile.sv
// AXI4-Lite slave exposing RW control registers and RO status registers to the
// PS, plus decoded core controls (reset, run, start pulse, write pulses).
module axil_riscv_ctrl_regfile
    import axil_riscv_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CTRL_REGS        = 8,
    parameter int NUM_STAT_REGS        = 4
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_areset,
    axil_riscv_ctrl_regfile_if.slave     s00_axi,
    output logic                         w_mem_reset_n,
    output logic                         w_run_pc_in,
    output logic                         w_start_pulse,
    output logic [32*NUM_CTRL_REGS-1:0]  w_ctrl_regs,
    output logic [NUM_CTRL_REGS-1:0]     w_reg_wr_pulse,
    input  logic [32*NUM_STAT_REGS-1:0]  w_stat_regs
);

    localparam int ADDR_W   = C_S00_AXI_ADDR_WIDTH;
    localparam int IDX_W    = ADDR_W - 2;
    localparam int NUM_REGS = total_regs(NUM_CTRL_REGS, NUM_STAT_REGS);

    if (C_S00_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axil_riscv_ctrl_regfile: C_S00_AXI_DATA_WIDTH must be 32");
    end
    if (ADDR_W < $clog2(NUM_REGS) + 2) begin : g_bad_addr_width
        $error("axil_riscv_ctrl_regfile: C_S00_AXI_ADDR_WIDTH too small");
    end
    if (NUM_CTRL_REGS < 2 || NUM_STAT_REGS < 1) begin : g_bad_reg_count
        $error("axil_riscv_ctrl_regfile: need >= 2 control and >= 1 status registers");
    end

    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              w_full_q, w_full_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    axi_resp_t         bresp_q, bresp_d;
    logic              start_pulse_q, start_pulse_d;
    logic [NUM_CTRL_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic              rvalid_q, rvalid_d;
    axi_resp_t         rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [NUM_CTRL_REGS-1:0] wr_sel, wr_en;
    logic [31:0]       ctrl_val [NUM_CTRL_REGS];

    // Ready is forced low combinationally while reset is held
    assign s00_axi.awready = !s00_axi_areset && !aw_full_q && !bvalid_q;
    assign s00_axi.wready  = !s00_axi_areset && !w_full_q && !bvalid_q;
    assign s00_axi.arready = !s00_axi_areset && !rvalid_q;

    // A beat arriving this cycle is used directly so AW+W together commit at once
    always_comb begin
        aw_hs   = s00_axi.awvalid && s00_axi.awready;
        w_hs    = s00_axi.wvalid && s00_axi.wready;
        wr_addr = aw_full_q ? awaddr_q : s00_axi.awaddr;
        wr_data = w_full_q ? wdata_q : s00_axi.wdata;
        wr_strb = w_full_q ? wstrb_q : s00_axi.wstrb;
        wr_idx  = wr_addr[ADDR_W-1:2];
        commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;

        wr_sel = '0;
        for (int i = 0; i < NUM_CTRL_REGS; i++) begin
            wr_sel[i] = (wr_idx == IDX_W'(i));
        end
        wr_en = commit ? wr_sel : '0;

        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = s00_axi.awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s00_axi.wdata;
            wstrb_d  = s00_axi.wstrb;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s00_axi.bready) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        start_pulse_d = commit && wr_sel[CTRL_REG_IDX] && wr_strb[0] && wr_data[CTRL_BIT_START];
        wr_pulse_d    = wr_en;
    end

    // Read mux samples the current register/status values, so a same-cycle write is not visible
    always_comb begin
        ar_hs    = s00_axi.arvalid && s00_axi.arready;
        rd_idx   = s00_axi.araddr[ADDR_W-1:2];
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s00_axi.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_CTRL_REGS; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = ctrl_val[i];
                end
            end
            for (int j = 0; j < NUM_STAT_REGS; j++) begin
                if (rd_idx == IDX_W'(NUM_CTRL_REGS + j)) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = w_stat_regs[32*j +: 32];
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            aw_full_q     <= 1'b0;
            awaddr_q      <= '0;
            w_full_q      <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            start_pulse_q <= 1'b0;
            wr_pulse_q    <= '0;
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
        end else begin
            aw_full_q     <= aw_full_d;
            awaddr_q      <= awaddr_d;
            w_full_q      <= w_full_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            start_pulse_q <= start_pulse_d;
            wr_pulse_q    <= wr_pulse_d;
            rvalid_q      <= rvalid_d;
            rresp_q       <= rresp_d;
            rdata_q       <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl
        localparam logic [31:0] MASK = (g == CTRL_REG_IDX) ? CTRL_REG0_STORE_MASK : 32'hFFFF_FFFF;
        axil_strb_reg #(.STORE_MASK(MASK)) u_reg (
            .clk   (s00_axi_aclk),
            .rst   (s00_axi_areset),
            .we    (wr_en[g]),
            .strb  (wr_strb),
            .wdata (wr_data),
            .q     (ctrl_val[g])
        );
        assign w_ctrl_regs[32*g +: 32] = ctrl_val[g];
    end

    assign s00_axi.bvalid = bvalid_q;
    assign s00_axi.bresp  = bresp_q;
    assign s00_axi.rvalid = rvalid_q;
    assign s00_axi.rresp  = rresp_q;
    assign s00_axi.rdata  = rdata_q;

    assign w_mem_reset_n  = ctrl_val[CTRL_REG_IDX][CTRL_BIT_MEM_RESET_N];
    assign w_run_pc_in    = ctrl_val[CTRL_REG_IDX][CTRL_BIT_RUN];
    assign w_start_pulse  = start_pulse_q;
    assign w_reg_wr_pulse = wr_pulse_q;

    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, wr_addr[1:0], s00_axi.araddr[1:0]};

endmodule
